// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, ALU encodings, FSM states
// and the decode bundle for the accumulator CPU controller.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_ADDR,
    S_FETCH_MEM,
    S_DECODE,
    S_EXEC_ADDR,
    S_EXEC_MEM,
    S_HALT
  } state_e;

  typedef struct packed {
    logic    mem;
    logic    store;
    logic    jmp;
    logic    jz;
    logic    halt;
    logic    ill;
    alu_op_e alu;
  } dec_t;

  function automatic logic is_mem_op(
    input logic [3:0] op
  );
    return op inside {OP_LDA, OP_STA, OP_ADD, OP_SUB};
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: memory request bus between the
// controller (master) and the memory (slave).
interface cpu_ctrl_if;

  logic mem_rd;
  logic mem_wr;
  logic mem_ready;

  modport master (
    output mem_rd,
    output mem_wr,
    input  mem_ready
  );

  modport slave (
    input  mem_rd,
    input  mem_wr,
    output mem_ready
  );

endinterface

// File: rtl/cpu_decode.sv
// cpu_decode: classifies IR[15:12] into memory,
// jump, halt and illegal instruction classes.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (opcode == OP_NOP): begin
        dec.mem = 1'b0;
      end
      is_mem_op(opcode): begin
        dec.mem   = 1'b1;
        dec.store = (opcode == OP_STA);
        if (opcode == OP_ADD) begin
          dec.alu = ALU_ADD;
        end else if (opcode == OP_SUB) begin
          dec.alu = ALU_SUB;
        end else begin
          dec.alu = ALU_PASS;
        end
      end
      (opcode == OP_JMP): dec.jmp  = 1'b1;
      (opcode == OP_JZ):  dec.jz   = 1'b1;
      (opcode == OP_HLT): dec.halt = 1'b1;
      default:            dec.ill  = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle control FSM for a 16-bit
// accumulator CPU, with retired-fetch counter.
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic        zero,
  cpu_ctrl_if.master  bus,
  output logic        mar_load,
  output logic        mar_sel,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        acc_load,
  output logic [1:0]  alu_op,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instr_count
);

  state_e      state_q;
  state_e      state_d;
  dec_t        dec;
  logic        ill_q;
  logic [15:0] cnt_q;
  logic        mem_rd;
  logic        mem_wr;

  cpu_decode u_dec (
    .opcode (opcode),
    .dec    (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && dec.ill) begin
        ill_q <= 1'b1;
      end
      if (ir_load) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mar_load = 1'b0;
    mar_sel  = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    acc_load = 1'b0;
    alu_op   = ALU_PASS;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH_ADDR;
        end
      end
      S_FETCH_ADDR: begin
        mar_load = 1'b1;
        state_d  = S_FETCH_MEM;
      end
      S_FETCH_MEM: begin
        mem_rd = 1'b1;
        if (bus.mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (dec.halt | dec.ill): state_d = S_HALT;
          dec.mem:              state_d = S_EXEC_ADDR;
          default: begin
            pc_load = dec.jmp | (dec.jz & zero);
            state_d = S_FETCH_ADDR;
          end
        endcase
      end
      S_EXEC_ADDR: begin
        mar_load = 1'b1;
        mar_sel  = 1'b1;
        state_d  = S_EXEC_MEM;
      end
      S_EXEC_MEM: begin
        // stores write, every other mem-type op reads
        mem_wr = dec.store;
        mem_rd = ~dec.store;
        if (bus.mem_ready) begin
          acc_load = ~dec.store;
          alu_op   = dec.store ? ALU_PASS : dec.alu;
          state_d  = S_FETCH_ADDR;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.mem_rd  = mem_rd;
  assign bus.mem_wr  = mem_wr;
  assign illegal     = ill_q;
  assign instr_count = cnt_q;

endmodule
